// File: rtl/store_queue.sv
// store_queue: store-side data-memory write path.
// Each store is aligned into byte lanes and held in an in-order queue.
// The queue drains to data memory over a valid/ready port.
// Loads probe the pending entries for overlap so that the hazard unit can stall them.
// Optional macro STORE_FORWARD_EN: a load that is fully covered by the youngest
// overlapping entry takes that entry's word instead of stalling.
module store_queue #(
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   st_valid,
  output logic                   st_ready,
  input  logic [2:0]             store_type,
  input  logic [31:0]            st_addr,
  input  logic [31:0]            st_data,
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic [31:0]            mem_req_addr,
  output logic [31:0]            mem_req_wdata,
  output logic [3:0]             mem_req_be,
  input  logic                   ld_check,
  input  logic [31:0]            ld_addr,
  input  logic [2:0]             ld_type,
  output logic                   ld_conflict,
  output logic                   fwd_hit,
  output logic [31:0]            fwd_data,
  output logic                   misaligned,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // The byte-lane mask is built from the access size (funct3[1:0]) and the byte offset.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   lane_mask = 4'b0001 << off;
      2'b01:   lane_mask = off[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  // Queue storage: word address, lane-aligned data, byte enables, occupancy
  logic [29:0]      ent_addr_q [DEPTH];
  logic [29:0]      ent_addr_d [DEPTH];
  logic [31:0]      ent_data_q [DEPTH];
  logic [31:0]      ent_data_d [DEPTH];
  logic [3:0]       ent_be_q   [DEPTH];
  logic [3:0]       ent_be_d   [DEPTH];
  logic [DEPTH-1:0] ent_valid_q, ent_valid_d;
  logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic             misaligned_q, misaligned_d;

  logic [31:0] st_wdata;
  logic [3:0]  st_be;
  logic        st_illegal;
  logic        st_fire, push, pop;

  // Store alignment and legality check
  always_comb begin
    st_wdata   = st_data;
    st_be      = lane_mask(store_type[1:0], st_addr[1:0]);
    st_illegal = 1'b0;
    case (store_type)
      3'b000: st_wdata = {4{st_data[7:0]}};
      3'b001: begin
        st_wdata   = {2{st_data[15:0]}};
        st_illegal = st_addr[0];
      end
      3'b010: st_illegal = |st_addr[1:0];
      default: st_illegal = 1'b1;
    endcase
  end

  // A full queue refuses stores even when it pops in the same cycle.
  assign st_ready      = (count_q != FULL);
  assign st_fire       = st_valid & st_ready;
  assign push          = st_fire & ~st_illegal;
  assign mem_req_valid = (count_q != '0);
  assign pop           = mem_req_valid & mem_req_ready;

  // Next-state logic for the queue: pop at the head, push at the tail.
  always_comb begin
    ent_addr_d   = ent_addr_q;
    ent_data_d   = ent_data_q;
    ent_be_d     = ent_be_q;
    ent_valid_d  = ent_valid_q;
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    misaligned_d = st_fire & st_illegal;
    if (pop) begin
      ent_valid_d[head_q] = 1'b0;
      head_d              = head_q + PW'(1);
    end
    if (push) begin
      ent_addr_d[tail_q]  = st_addr[31:2];
      ent_data_d[tail_q]  = st_wdata;
      ent_be_d[tail_q]    = st_be;
      ent_valid_d[tail_q] = 1'b1;
      tail_d              = tail_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Queue state registers. Reset discards all entries immediately.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_addr_q[i] <= '0;
        ent_data_q[i] <= '0;
        ent_be_q[i]   <= '0;
      end
      ent_valid_q  <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      misaligned_q <= 1'b0;
    end else begin
      ent_addr_q   <= ent_addr_d;
      ent_data_q   <= ent_data_d;
      ent_be_q     <= ent_be_d;
      ent_valid_q  <= ent_valid_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      misaligned_q <= misaligned_d;
    end
  end

  // The memory port is driven straight from the registered head entry, and is zero while empty.
  assign mem_req_addr  = mem_req_valid ? {ent_addr_q[head_q], 2'b00} : '0;
  assign mem_req_wdata = mem_req_valid ? ent_data_q[head_q] : '0;
  assign mem_req_be    = mem_req_valid ? ent_be_q[head_q] : '0;
  assign misaligned    = misaligned_q;
  assign count         = count_q;
  assign empty         = (count_q == '0);

  // Load probe: a per-entry overlap on the same word with at least one shared byte lane
  logic [3:0]       ld_mask;
  logic [DEPTH-1:0] overlap;
  assign ld_mask = lane_mask(ld_type[1:0], ld_addr[1:0]);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_probe
    assign overlap[gi] = ent_valid_q[gi] && (ent_addr_q[gi] == ld_addr[31:2]) &&
                         (|(ent_be_q[gi] & ld_mask));
  end

  // Sign-extension bit of the load funct3 has no bearing on overlap
  logic unused_ld_type;
  assign unused_ld_type = ld_type[2];

`ifdef STORE_FORWARD_EN
  logic [PW-1:0] young_idx;
  logic          young_found;
  logic          full_cover;

  // Scan from oldest to youngest so the last overlapping entry found is the youngest.
  always_comb begin
    logic [PW-1:0] idx;
    young_idx   = '0;
    young_found = 1'b0;
    idx         = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if (overlap[idx]) begin
        young_idx   = idx;
        young_found = 1'b1;
      end
    end
  end

  assign full_cover  = ((ent_be_q[young_idx] & ld_mask) == ld_mask);
  assign fwd_hit     = ld_check & young_found & full_cover;
  assign ld_conflict = ld_check & young_found & ~full_cover;
  assign fwd_data    = fwd_hit ? ent_data_q[young_idx] : '0;
`else
  assign ld_conflict = ld_check & (|overlap);
  assign fwd_hit     = 1'b0;
  assign fwd_data    = '0;
`endif

endmodule

// File: tb/tb_store_queue.sv
// tb_store_queue: directed and randomized stimulus checked against a queue-based model.
module tb_store_queue;
  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        st_valid = 1'b0;
  logic        st_ready;
  logic [2:0]  store_type = '0;
  logic [31:0] st_addr = '0;
  logic [31:0] st_data = '0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_be;
  logic        ld_check = 1'b0;
  logic [31:0] ld_addr = '0;
  logic [2:0]  ld_type = '0;
  logic        ld_conflict;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic        misaligned;
  logic [$clog2(DEPTH):0] count;
  logic        empty;

  store_queue #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset_n(reset_n),
    .st_valid(st_valid), .st_ready(st_ready), .store_type(store_type),
    .st_addr(st_addr), .st_data(st_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_be(mem_req_be),
    .ld_check(ld_check), .ld_addr(ld_addr), .ld_type(ld_type),
    .ld_conflict(ld_conflict), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .misaligned(misaligned), .count(count), .empty(empty)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } ent_t;

  ent_t mq[$];
  logic exp_mis = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] m_mask(input logic [1:0] size, input logic [31:0] a);
    int off;
    off = int'(a % 4);
    if (size == 2'd0) return 4'(1 << off);
    if (size == 2'd1) return (off >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic bit m_legal(input logic [2:0] t, input logic [31:0] a);
    if (t == 3'd0) return 1'b1;
    if (t == 3'd1) return (a % 2) == 0;
    if (t == 3'd2) return (a % 4) == 0;
    return 1'b0;
  endfunction

  function automatic ent_t m_entry(input logic [2:0] t, input logic [31:0] a, input logic [31:0] d);
    ent_t e;
    e.addr = a;
    e.be   = m_mask(t[1:0], a);
    if (t == 3'd0)      e.data = {24'h0, d[7:0]} * 32'h01010101;
    else if (t == 3'd1) e.data = {16'h0, d[15:0]} * 32'h00010001;
    else                e.data = d;
    return e;
  endfunction

  // Registered outputs against the model, sampled at the falling edge
  task automatic check_regs();
    chk("count", 32'(count), 32'(mq.size()));
    chk("empty", 32'(empty), 32'(mq.size() == 0));
    chk("st_ready", 32'(st_ready), 32'(mq.size() < DEPTH));
    chk("mem_req_valid", 32'(mem_req_valid), 32'(mq.size() > 0));
    chk("misaligned", 32'(misaligned), 32'(exp_mis));
    if (mq.size() > 0) begin
      chk("mem_req_addr", mem_req_addr, mq[0].addr & 32'hFFFF_FFFC);
      chk("mem_req_wdata", mem_req_wdata, mq[0].data);
      chk("mem_req_be", 32'(mem_req_be), 32'(mq[0].be));
    end
  endtask

  // Combinational load-probe outputs against the model
  task automatic check_probe();
    logic [3:0]  m;
    logic        ec, eh;
    logic [31:0] ed;
    int          y;
    ec = 1'b0; eh = 1'b0; ed = '0; y = -1;
    if (ld_check) begin
      m = m_mask(ld_type[1:0], ld_addr);
      for (int i = mq.size() - 1; i >= 0; i--)
        if (y < 0 && (mq[i].addr >> 2) == (ld_addr >> 2) && (mq[i].be & m) != 0) y = i;
`ifdef STORE_FORWARD_EN
      if (y >= 0) begin
        if ((mq[y].be & m) == m) begin
          eh = 1'b1;
          ed = mq[y].data;
        end else begin
          ec = 1'b1;
        end
      end
`else
      ec = (y >= 0);
`endif
    end
    chk("ld_conflict", 32'(ld_conflict), 32'(ec));
    chk("fwd_hit", 32'(fwd_hit), 32'(eh));
    chk("fwd_data", fwd_data, ed);
  endtask

  // One clock cycle: drive at the falling edge, probe-check, update model at the rising edge, check registers
  task automatic step(input logic sv, input logic [2:0] stt, input logic [31:0] sa, input logic [31:0] sd,
                      input logic rdy, input logic lc, input logic [31:0] la, input logic [2:0] lt);
    bit fire, do_pop, do_push, legal;
    st_valid = sv; store_type = stt; st_addr = sa; st_data = sd;
    mem_req_ready = rdy; ld_check = lc; ld_addr = la; ld_type = lt;
    #1;
    check_probe();
    legal   = m_legal(stt, sa);
    fire    = sv && (mq.size() < DEPTH);
    do_pop  = rdy && (mq.size() > 0);
    do_push = fire && legal;
    @(posedge clock);
    if (do_pop) begin
      $display("[TB] write addr=%h data=%h be=%b", mq[0].addr & 32'hFFFF_FFFC, mq[0].data, mq[0].be);
      void'(mq.pop_front());
    end
    if (do_push) mq.push_back(m_entry(stt, sa, sd));
    exp_mis = fire && !legal;
    @(negedge clock);
    check_regs();
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 3'd0, 32'h0, 32'h0, rdy, 1'b0, 32'h0, 3'd0);
  endtask

  // Hold the queue still and probe with a load; the caller checks the literals
  task automatic probe(input logic [31:0] la, input logic [2:0] lt);
    st_valid = 1'b0; mem_req_ready = 1'b0;
    ld_check = 1'b1; ld_addr = la; ld_type = lt;
    #1;
  endtask

  task automatic do_reset();
    st_valid = 1'b0; mem_req_ready = 1'b0; ld_check = 1'b0;
    reset_n = 1'b0;
    #1;
    mq.delete();
    exp_mis = 1'b0;
    chk("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_st_ready", 32'(st_ready), 32'd1);
    chk("rst_mem_req_addr", mem_req_addr, 32'd0);
    chk("rst_mem_req_wdata", mem_req_wdata, 32'd0);
    chk("rst_mem_req_be", 32'(mem_req_be), 32'd0);
    chk("rst_misaligned", 32'(misaligned), 32'd0);
    chk("rst_ld_conflict", 32'(ld_conflict), 32'd0);
    chk("rst_fwd_hit", 32'(fwd_hit), 32'd0);
    chk("rst_fwd_data", fwd_data, 32'd0);
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  initial begin
    logic [2:0] rt;
    @(negedge clock);
    do_reset();

    // Byte store at the top lane drains one cycle after it is enqueued
    step(1'b1, 3'd0, 32'h1003, 32'h0000_00AB, 1'b1, 1'b0, 32'h0, 3'd0);
    chk("sb_addr", mem_req_addr, 32'h0000_1000);
    chk("sb_wdata", mem_req_wdata, 32'hABAB_ABAB);
    chk("sb_be", 32'(mem_req_be), 32'h8);
    idle(1'b1);
    chk("sb_drained_empty", 32'(empty), 32'd1);

    // Fill the queue with five stores: the fifth is refused
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 3'd2, 32'h100 + 32'(4 * i), 32'hC0DE_0000 + 32'(i), 1'b0, 1'b0, 32'h0, 3'd0);
      if (i == 3) chk("full_st_ready", 32'(st_ready), 32'd0);
    end
    chk("full_count", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) idle(1'b1);
    chk("drained_count", 32'(count), 32'd0);

    // Illegal stores pulse misaligned for one cycle and are not enqueued
    step(1'b1, 3'd1, 32'h2001, 32'h1234, 1'b0, 1'b0, 32'h0, 3'd0);
    chk("sh_odd_misaligned", 32'(misaligned), 32'd1);
    chk("sh_odd_count", 32'(count), 32'd0);
    idle(1'b0);
    chk("misaligned_clears", 32'(misaligned), 32'd0);
    step(1'b1, 3'd3, 32'h2000, 32'h1234, 1'b0, 1'b0, 32'h0, 3'd0);
    chk("type3_misaligned", 32'(misaligned), 32'd1);
    chk("type3_count", 32'(count), 32'd0);
    idle(1'b0);

    // Word store followed by a byte load inside it
    step(1'b1, 3'd2, 32'h3000, 32'h1122_3344, 1'b0, 1'b0, 32'h0, 3'd0);
    probe(32'h3002, 3'd0);
`ifdef STORE_FORWARD_EN
    chk("lb_fwd_hit", 32'(fwd_hit), 32'd1);
    chk("lb_fwd_data", fwd_data, 32'h1122_3344);
    chk("lb_conflict", 32'(ld_conflict), 32'd0);
`else
    chk("lb_conflict", 32'(ld_conflict), 32'd1);
    chk("lb_fwd_hit", 32'(fwd_hit), 32'd0);
`endif
    // A younger byte store only partly covers a word load
    step(1'b1, 3'd0, 32'h3001, 32'h55, 1'b0, 1'b0, 32'h0, 3'd0);
    probe(32'h3000, 3'd2);
    chk("lw_partial_conflict", 32'(ld_conflict), 32'd1);
    chk("lw_partial_fwd_hit", 32'(fwd_hit), 32'd0);
    probe(32'h3004, 3'd2);
    chk("lw_other_conflict", 32'(ld_conflict), 32'd0);
    chk("lw_other_fwd_hit", 32'(fwd_hit), 32'd0);

    // Simultaneous push and pop at count 2
    step(1'b1, 3'd2, 32'h4000, 32'h99, 1'b1, 1'b0, 32'h0, 3'd0);
    chk("pushpop_count", 32'(count), 32'd2);
    for (int i = 0; i < 3; i++) idle(1'b1);

    // Pointer wrap over several laps
    for (int i = 0; i < 3 * DEPTH; i++)
      step(1'b1, 3'd2, 32'h5000 + 32'(4 * i), $urandom, 1'($urandom_range(0, 1)), 1'b0, 32'h0, 3'd0);
    for (int i = 0; i < 2 * DEPTH; i++) idle(1'b1);
    chk("wrap_drained", 32'(count), 32'd0);

    // Randomized traffic with a reset in the middle
    for (int c = 0; c < 2000; c++) begin
      if (c == 1000) do_reset();
      rt = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      step(1'($urandom_range(0, 3) != 0), rt, 32'h3000 + 32'($urandom_range(0, 15)), $urandom,
           1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
           32'h3000 + 32'($urandom_range(0, 15)),
           {1'($urandom_range(0, 1)), 2'($urandom_range(0, 2))});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
